// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arms on request, waits for a software or synchronised
// external trigger, then issues decimated FIFO writes until a sample count, an overflow or an abort.
module adc_capture_ctrl #(
    parameter int CNT_W = 16,
    parameter int DEC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_sel,
    input  logic             sw_trig,
    input  logic             ext_trig,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [DEC_W-1:0] decim,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done,
    output logic             ovf_err,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        OVF     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [2:0]       ext_sync_q;
    logic [2:0]       primed_q;
    logic             ext_edge;
    logic             trig;
    logic             slot;
    logic             reached;

    // Bits 0/1 are the synchroniser, bit 2 the edge-detect history. The primed
    // shift register masks the edge detector until the history holds a real
    // sample, so a level already high at reset is not taken as an edge.
    assign ext_edge = ext_sync_q[1] & ~ext_sync_q[2] & primed_q[2];
    assign trig     = trig_sel ? ext_edge : sw_trig;
    assign slot     = (dec_cnt_q == dec_q);
    assign reached  = (num_q != '0) && (cnt_q == num_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q <= '0;
            primed_q   <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[1:0], ext_trig};
            primed_q   <= {primed_q[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            num_q     <= '0;
            dec_q     <= '0;
            dec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            dec_q     <= dec_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        cnt_d     = cnt_q;
        num_d     = num_q;
        dec_d     = dec_q;
        dec_cnt_d = dec_cnt_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE, OVF: begin
                    if (arm) begin
                        state_d   = ARMED;
                        cnt_d     = '0;
                        dec_cnt_d = '0;
                        num_d     = num_samples;
                        dec_d     = decim;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        dec_cnt_d = '0;
                        if (fifo_full) begin
                            state_d = OVF;
                        end else begin
                            state_d = CAPTURE;
                            wr_d    = 1'b1;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    // The count check precedes the slot so exactly num writes occur.
                    if (reached) begin
                        state_d = DONE;
                    end else if (slot) begin
                        dec_cnt_d = '0;
                        if (fifo_full) begin
                            state_d = OVF;
                        end else begin
                            wr_d  = 1'b1;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q + DEC_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifo_wr_en = wr_q;
    assign state      = state_q;
    assign busy       = (state_q == ARMED) || (state_q == CAPTURE);
    assign done       = (state_q == DONE);
    assign ovf_err    = (state_q == OVF);
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: a cycle-level behavioural model of the capture
// rules checked every cycle, plus directed scenarios with literal expectations.
module tb_adc_capture_ctrl;

    localparam int CNT_W = 16;
    localparam int DEC_W = 8;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAPT = 2, S_DONE = 3, S_OVF = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic             trig_sel = 1'b0;
    logic             sw_trig = 1'b0;
    logic             ext_trig = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic [DEC_W-1:0] decim = '0;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en;
    logic [2:0]       state;
    logic             busy;
    logic             done;
    logic             ovf_err;
    logic [CNT_W-1:0] sample_cnt;

    int errors = 0;
    int checks = 0;
    int wr_total = 0;

    adc_capture_ctrl #(.CNT_W(CNT_W), .DEC_W(DEC_W)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_sel(trig_sel),
        .sw_trig(sw_trig), .ext_trig(ext_trig), .num_samples(num_samples),
        .decim(decim), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .state(state), .busy(busy), .done(done), .ovf_err(ovf_err),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: capture described as cycles since trigger, with a
    // write whenever that count is a multiple of decim+1.
    int          m_st;
    bit          m_wr;
    logic [15:0] m_cnt;
    logic [15:0] m_n;
    int          m_d;
    int          m_c;
    bit          ext_hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = S_IDLE; m_wr = 0; m_cnt = 0; m_n = 0; m_d = 0; m_c = 0;
            ext_hist.delete();
        end else begin
            bit ext_evt;
            bit t;
            int sz;
            sz = ext_hist.size();
            // Edge seen in the synchronised stream: the sample two edges back is
            // high and the one three edges back is low; needs three samples since reset.
            ext_evt = (sz >= 3) && ext_hist[sz-2] && !ext_hist[sz-3];
            ext_hist.push_back(ext_trig);
            if (ext_hist.size() > 4) void'(ext_hist.pop_front());
            t = trig_sel ? ext_evt : sw_trig;
            m_wr = 0;
            if (abort) begin
                m_st = S_IDLE;
            end else if (m_st == S_ARMED) begin
                if (t) begin
                    m_c = 0;
                    if (fifo_full) m_st = S_OVF;
                    else begin m_st = S_CAPT; m_wr = 1; m_cnt = 1; end
                end
            end else if (m_st == S_CAPT) begin
                m_c++;
                if (m_n != 0 && m_cnt == m_n) m_st = S_DONE;
                else if (m_c % (m_d + 1) == 0) begin
                    if (fifo_full) m_st = S_OVF;
                    else begin m_wr = 1; m_cnt = m_cnt + 16'd1; end
                end
            end else if (arm) begin
                m_st = S_ARMED; m_cnt = 0; m_n = num_samples; m_d = int'(decim);
            end
        end
    end

    always @(negedge clk) begin
        wr_total += int'(fifo_wr_en);
        chk("cyc_state", int'(state), m_st);
        chk("cyc_wr_en", int'(fifo_wr_en), int'(m_wr));
        chk("cyc_cnt", int'(sample_cnt), int'(m_cnt));
        chk("cyc_busy", int'(busy), int'(m_st == S_ARMED || m_st == S_CAPT));
        chk("cyc_done", int'(done), int'(m_st == S_DONE));
        chk("cyc_ovf", int'(ovf_err), int'(m_st == S_OVF));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm(input int n, input int d);
        num_samples = CNT_W'(n);
        decim = DEC_W'(d);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        num_samples = CNT_W'($urandom_range(1, 200));
        decim = DEC_W'($urandom_range(0, 9));
    endtask

    task automatic pulse_sw();
        sw_trig = 1'b1;
        tick(1);
        sw_trig = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    initial begin
        int lat;
        int wr_before;
        logic [7:0] mask;
        mask = 8'b0100_1001;

        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("reset_state", int'(state), 0);
        chk("reset_cnt", int'(sample_cnt), 0);

        // Four back-to-back writes, then DONE.
        do_arm(4, 0);
        chk("armed_busy", int'(busy), 1);
        pulse_sw();
        for (int i = 0; i < 4; i++) begin
            chk("dec0_wr", int'(fifo_wr_en), 1);
            tick(1);
        end
        chk("dec0_wr_end", int'(fifo_wr_en), 0);
        chk("dec0_state", int'(state), 3);
        chk("dec0_cnt", int'(sample_cnt), 4);
        chk("dec0_done", int'(done), 1);

        // Decimation by three: writes at cycles 0,3,6, DONE at 7.
        do_arm(3, 2);
        pulse_sw();
        for (int i = 0; i < 8; i++) begin
            chk("dec2_wr", int'(fifo_wr_en), int'(mask[i]));
            if (i == 6) chk("dec2_state6", int'(state), 2);
            if (i == 7) chk("dec2_state7", int'(state), 3);
            tick(1);
        end

        // External trigger: latency and single capture while held high.
        trig_sel = 1'b1;
        do_arm(2, 0);
        wr_before = wr_total;
        lat = 0;
        @(posedge clk);
        #2 ext_trig = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && fifo_wr_en) lat = k;
        end
        checks++;
        if (lat < 3 || lat > 4) begin
            errors++;
            $display("FAIL ext_latency: got %0d edges, expected 3..4", lat);
        end
        @(negedge clk);
        tick(10);
        chk("ext_writes", wr_total - wr_before, 2);
        chk("ext_done", int'(state), 3);
        do_arm(2, 0);
        tick(10);
        chk("ext_held_armed", int'(state), 1);
        chk("ext_held_writes", wr_total - wr_before, 2);
        #3 ext_trig = 1'b0;
        @(negedge clk);
        pulse_abort();
        trig_sel = 1'b0;

        // Overflow before the fifth write.
        do_arm(8, 0);
        pulse_sw();
        tick(3);
        fifo_full = 1'b1;
        tick(1);
        chk("ovf_state", int'(state), 4);
        chk("ovf_cnt", int'(sample_cnt), 4);
        chk("ovf_flag", int'(ovf_err), 1);
        wr_before = wr_total;
        tick(5);
        chk("ovf_no_wr", wr_total - wr_before, 0);
        fifo_full = 1'b0;
        do_arm(2, 0);
        chk("ovf_rearm_state", int'(state), 1);
        chk("ovf_rearm_flag", int'(ovf_err), 0);
        chk("ovf_rearm_cnt", int'(sample_cnt), 0);

        // Abort priority, and triggers in IDLE are not queued.
        pulse_abort();
        abort = 1'b1; arm = 1'b1;
        tick(1);
        abort = 1'b0; arm = 1'b0;
        chk("arm_abort_state", int'(state), 0);
        pulse_sw();
        do_arm(0, 1);
        tick(3);
        chk("no_queued_trig", int'(state), 1);
        pulse_sw();
        tick(3);
        pulse_abort();
        chk("abort_wr", int'(fifo_wr_en), 0);
        chk("abort_state", int'(state), 0);

        // Reset mid continuous capture, with ext_trig high across reset.
        do_arm(0, 1);
        pulse_sw();
        tick(20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        trig_sel = 1'b1;
        ext_trig = 1'b1;
        #1;
        chk("rst_wr", int'(fifo_wr_en), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_cnt", int'(sample_cnt), 0);
        chk("rst_flags", int'({busy, done, ovf_err}), 0);
        tick(2);
        rst_n = 1'b1;
        wr_before = wr_total;
        do_arm(5, 0);
        tick(8);
        chk("rst_ext_high_armed", int'(state), 1);
        chk("rst_no_wr", wr_total - wr_before, 0);
        ext_trig = 1'b0;
        tick(3);
        #3 ext_trig = 1'b1;
        @(negedge clk);
        tick(10);
        chk("rst_recapture", wr_total - wr_before, 5);
        chk("rst_recap_state", int'(state), 3);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
